// File: rtl/bht_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bht_predictor: PC-indexed 2-bit counter BHT with in-flight prediction FIFO  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module bht_predictor #(
  parameter int INDEX_BITS = 4,
  parameter int PC_WIDTH   = 32,
  parameter int QDEPTH     = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      lookup_valid,
  input  logic [PC_WIDTH-1:0]       lookup_pc,
  output logic                      lookup_ready,
  output logic                      predict_taken,
  input  logic                      resolve_valid,
  input  logic                      resolve_taken,
  output logic                      mispredict,
  output logic [$clog2(QDEPTH):0]   pending_count
);

  localparam int                 c_ENTRIES   = 2 ** INDEX_BITS;
  localparam int                 c_PTR_W     = $clog2(QDEPTH);
  localparam int                 c_CNT_W     = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL      = c_CNT_W'(QDEPTH);
  localparam logic [1:0]         c_CNT_RESET = 2'b01;

  logic [1:0]            r_cnt [c_ENTRIES];
  logic [INDEX_BITS-1:0] r_q_idx [QDEPTH];
  logic [QDEPTH-1:0]     r_q_pred;
  logic [c_PTR_W-1:0]    r_head;
  logic [c_PTR_W-1:0]    r_tail;
  logic [c_CNT_W-1:0]    r_count;
  logic                  r_mispredict;

  logic [INDEX_BITS-1:0] w_index;
  logic                  w_predict;
  logic                  w_ready;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_flush;
  logic                  w_enq;
  logic [INDEX_BITS-1:0] w_head_idx;
  logic                  w_head_pred;
  logic [1:0]            w_head_cnt;
  logic [1:0]            w_trained;
  logic                  w_unused_pc_bits;

  assign w_index          = lookup_pc[INDEX_BITS+1:2];
  assign w_unused_pc_bits = ^{lookup_pc[PC_WIDTH-1:INDEX_BITS+2], lookup_pc[1:0]};
  assign w_predict        = r_cnt[w_index][1];
  assign w_ready          = (r_count != c_FULL);
  assign w_push           = lookup_valid & w_ready;
  assign w_pop            = resolve_valid & (r_count != '0);
  assign w_head_idx       = r_q_idx[r_head];
  assign w_head_pred      = r_q_pred[r_head];
  assign w_flush          = w_pop & (resolve_taken != w_head_pred);
  // Younger entries behind a mispredict are wrong-path, so a same-cycle push is dropped.
  assign w_enq            = w_push & ~w_flush;
  assign w_head_cnt       = r_cnt[w_head_idx];

  always_comb begin
    w_trained = w_head_cnt;
    if (resolve_taken) begin
      if (w_head_cnt != 2'b11) w_trained = w_head_cnt + 2'd1;
    end else begin
      if (w_head_cnt != 2'b00) w_trained = w_head_cnt - 2'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < c_ENTRIES; i++) r_cnt[i] <= c_CNT_RESET;
    end else if (w_pop) begin
      r_cnt[w_head_idx] <= w_trained;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < QDEPTH; i++) r_q_idx[i] <= '0;
      r_q_pred <= '0;
    end else if (w_enq) begin
      r_q_idx[r_tail]  <= w_index;
      r_q_pred[r_tail] <= w_predict;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_mispredict <= 1'b0;
    end else begin
      r_mispredict <= w_flush;
      if (w_flush) begin
        r_head  <= r_tail;
        r_count <= '0;
      end else begin
        if (w_enq) r_tail <= r_tail + c_PTR_W'(1);
        if (w_pop) r_head <= r_head + c_PTR_W'(1);
        case ({w_enq, w_pop})
          2'b10:   r_count <= r_count + c_CNT_W'(1);
          2'b01:   r_count <= r_count - c_CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign lookup_ready  = w_ready;
  assign predict_taken = w_predict;
  assign mispredict    = r_mispredict;
  assign pending_count = r_count;

endmodule
`default_nettype wire
